// File: rtl/sprite_scaler.sv
// rtl/sprite_scaler.sv - screen-to-texel address generator and keyed overlay pixel for one scaled sprite
module sprite_scaler #(
    parameter int H_VIEW       = 640,
    parameter int V_VIEW       = 480,
    parameter int FRAC         = 10,
    parameter int CHANNEL_BITS = 2,
    parameter logic [3*CHANNEL_BITS-1:0] KEY = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [9:0]                h,
    input  logic [9:0]                v,
    input  logic                      load,
    input  logic [9:0]                spr_x,
    input  logic [9:0]                spr_y,
    input  logic [9:0]                spr_size,
    output logic                      busy,
    output logic [5:0]                rom_col,
    output logic [5:0]                rom_row,
    input  logic [3*CHANNEL_BITS-1:0] rom_val,
    output logic                      pix_en,
    output logic [3*CHANNEL_BITS-1:0] pix_rgb
);
    localparam int AW    = FRAC + 7;
    localparam int CNT_W = $clog2(AW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AW - 1);
    localparam logic [AW-1:0]    DIVIDEND = AW'(64) << FRAC;

    typedef enum logic [1:0] {IDLE, DIVIDE, ARMED} state_t;
    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    dvd;
    logic [AW-2:0]    quo;
    logic [9:0]       rem;
    logic [AW-1:0]    step;
    logic [AW-1:0]    col_acc, row_acc;
    logic [9:0]       x_reg, y_reg, size_reg;

    logic [10:0]   trial;
    logic          ge;
    logic [9:0]    rem_next;
    logic [AW-1:0] quo_next;
    logic          div_done;
    logic [10:0]   dh, dv;
    logic          in_h, in_v, line_end, frame_end, pix_en_next;

    // Restoring divide: shift one dividend bit into the remainder per cycle
    assign trial    = {rem, dvd[AW-1]};
    assign ge       = trial >= {1'b0, size_reg};
    assign rem_next = ge ? 10'(trial - {1'b0, size_reg}) : trial[9:0];
    assign quo_next = {quo, ge};
    assign div_done = (state == DIVIDE) && (cnt == CNT_LAST);

    // Offsets wrap to >=1024 when h<x, which always exceeds any size
    assign dh        = {1'b0, h} - {1'b0, x_reg};
    assign dv        = {1'b0, v} - {1'b0, y_reg};
    assign in_h      = (dh < {1'b0, size_reg}) && (h < 10'(H_VIEW));
    assign in_v      = (dv < {1'b0, size_reg}) && (v < 10'(V_VIEW));
    assign line_end  = (h == 10'(H_VIEW - 1));
    assign frame_end = (v == 10'(V_VIEW - 1));

    assign pix_en_next = (state == ARMED) && in_h && in_v && (rom_val != KEY);
    assign busy        = (state == DIVIDE);
    assign rom_col     = col_acc[FRAC+5:FRAC];
    assign rom_row     = row_acc[FRAC+5:FRAC];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (load)          state_next = (spr_size != 10'd0) ? DIVIDE : IDLE;
        else if (div_done) state_next = ARMED;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            dvd      <= '0;
            quo      <= '0;
            rem      <= '0;
            step     <= '0;
            x_reg    <= '0;
            y_reg    <= '0;
            size_reg <= '0;
        end else if (load) begin
            x_reg    <= spr_x;
            y_reg    <= spr_y;
            size_reg <= spr_size;
            cnt      <= '0;
            dvd      <= DIVIDEND;
            quo      <= '0;
            rem      <= '0;
        end else if (state == DIVIDE) begin
            cnt <= cnt + CNT_W'(1);
            dvd <= dvd << 1;
            rem <= rem_next;
            quo <= quo_next[AW-2:0];
            if (cnt == CNT_LAST) step <= quo_next;
        end
    end

    // Line end wins over advance; load wins over everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_acc <= '0;
            row_acc <= '0;
        end else if (load) begin
            col_acc <= '0;
            row_acc <= '0;
        end else begin
            if (line_end)         col_acc <= '0;
            else if (in_h && in_v) col_acc <= col_acc + step;
            if (line_end) begin
                if (frame_end)  row_acc <= '0;
                else if (in_v)  row_acc <= row_acc + step;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_en  <= 1'b0;
            pix_rgb <= '0;
        end else begin
            pix_en  <= pix_en_next;
            pix_rgb <= pix_en_next ? rom_val : '0;
        end
    end
endmodule

// File: tb/tb_sprite_scaler.sv
// tb/tb_sprite_scaler.sv - randomized and directed bench for sprite_scaler against a texel-count model
module tb_sprite_scaler;
    localparam int FRAC     = 10;
    localparam int H        = 640;
    localparam int V        = 480;
    localparam int BUSY_CYC = FRAC + 7;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] h = '0, v = '0, spr_x = '0, spr_y = '0, spr_size = '0;
    logic       load = 1'b0;
    logic       busy, pix_en;
    logic [5:0] rom_col, rom_row, rom_val, pix_rgb;

    int checks = 0;
    int errors = 0;
    int rom_mode = 0;

    // Model: texel index = (pixels so far * step) >> FRAC, step = (64<<FRAC)/size
    int m_x, m_y, m_size, m_step, m_k, m_j, m_busy_left, m_en, m_rgb;
    bit m_armed;

    function automatic logic [5:0] rom_fn(input int mode, input int col, input int row);
        case (mode)
            0:       return 6'(((col + row) % 63) + 1);
            1:       return (col < 32) ? 6'd0 : 6'(((col + 2 * row) % 63) + 1);
            default: return 6'((col * 7 + row * 3) % 64);
        endcase
    endfunction

    assign rom_val = rom_fn(rom_mode, int'(rom_col), int'(rom_row));

    sprite_scaler dut (
        .clk(clk), .reset_n(reset_n), .h(h), .v(v), .load(load),
        .spr_x(spr_x), .spr_y(spr_y), .spr_size(spr_size), .busy(busy),
        .rom_col(rom_col), .rom_row(rom_row), .rom_val(rom_val),
        .pix_en(pix_en), .pix_rgb(pix_rgb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_size = 0; m_step = 0; m_k = 0; m_j = 0;
        m_busy_left = 0; m_en = 0; m_rgb = 0; m_armed = 0;
    endtask

    task automatic model_step(input int hh, input int vv, input bit ld,
                              input int sx, input int sy, input int ss);
        bit inh, inv;
        int col, row, rv;
        inh = hh >= m_x && hh < m_x + m_size && hh < H;
        inv = vv >= m_y && vv < m_y + m_size && vv < V;
        col = ((m_k * m_step) >> FRAC) % 64;
        row = ((m_j * m_step) >> FRAC) % 64;
        rv  = int'(rom_fn(rom_mode, col, row));
        m_en  = (m_armed && inh && inv && rv != 0) ? 1 : 0;
        m_rgb = m_en ? rv : 0;
        if (ld) begin
            m_x = sx; m_y = sy; m_size = ss;
            m_k = 0; m_j = 0; m_armed = 0;
            m_busy_left = (ss != 0) ? BUSY_CYC : 0;
        end else begin
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    m_armed = 1;
                    m_step  = (64 << FRAC) / m_size;
                end
            end
            if (hh == H - 1)       m_k = 0;
            else if (inh && inv)   m_k++;
            if (hh == H - 1) begin
                if (vv == V - 1)   m_j = 0;
                else if (inv)      m_j++;
            end
        end
    endtask

    always begin
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step(int'(h), int'(v), load, int'(spr_x), int'(spr_y), int'(spr_size));
        #1;
        chk("busy", int'(busy), (m_busy_left > 0) ? 1 : 0);
        chk("pix_en", int'(pix_en), m_en);
        chk("pix_rgb", int'(pix_rgb), m_rgb);
        chk("rom_col", int'(rom_col), ((m_k * m_step) >> FRAC) % 64);
        chk("rom_row", int'(rom_row), ((m_j * m_step) >> FRAC) % 64);
    end

    task automatic drive(input int hh, input int vv, input bit ld,
                         output int pcol, output int prow, output int pen, output int pbusy);
        h = 10'(hh); v = 10'(vv); load = ld;
        #1;
        pcol = int'(rom_col);
        prow = int'(rom_row);
        @(negedge clk);
        pen   = int'(pix_en);
        pbusy = int'(busy);
        load  = 1'b0;
    endtask

    task automatic do_load(input int x, input int y, input int size, output int busy_cnt);
        int c, r, e, b;
        spr_x = 10'(x); spr_y = 10'(y); spr_size = 10'(size);
        drive(0, 500, 1'b1, c, r, e, b);
        busy_cnt = b;
        for (int i = 1; i <= 24; i++) begin
            drive(i, 500, 1'b0, c, r, e, b);
            busy_cnt += b;
        end
    endtask

    task automatic scan_frame(input int x, input int y, input int size, input int pin, output int en_cnt);
        int c, r, e, b, lo_v, hi_v, lo_h, hi_h;
        en_cnt = 0;
        lo_v = (y > 2) ? y - 2 : 0;
        hi_v = (y + size + 1 < V) ? y + size + 1 : V - 1;
        lo_h = (x > 2) ? x - 2 : 0;
        hi_h = (x + size + 1 < H) ? x + size + 1 : H - 1;
        for (int vv = lo_v; vv <= hi_v; vv++) begin
            for (int hh = lo_h; hh <= hi_h; hh++) begin
                bit inw;
                drive(hh, vv, 1'b0, c, r, e, b);
                en_cnt += e;
                inw = hh >= x && hh < x + size && vv >= y && vv < y + size;
                if (pin == 1 && inw) begin
                    chk("pin_col", c, hh - x);
                    chk("pin_row", r, vv - y);
                    chk("pin_en", e, 1);
                end
                if (pin == 2 && (vv == 50 || vv == 51)) begin
                    if (hh == 100 || hh == 101) begin
                        chk("p128_col0", c, 0);
                        chk("p128_row0", r, 0);
                    end
                    if (hh == 227) begin
                        chk("p128_col63", c, 63);
                        chk("p128_en227", e, 1);
                    end
                    if (hh == 228) chk("p128_en228", e, 0);
                end
                if (pin == 3 && inw) chk("key_en", e, (hh - x >= 32) ? 1 : 0);
                if (pin == 4 && inw) chk("clip_col", c, hh - 600);
            end
            if (hi_h != H - 1) begin
                drive(H - 1, vv, 1'b0, c, r, e, b);
                en_cnt += e;
            end
        end
        drive(H - 1, V - 1, 1'b0, c, r, e, b);
        en_cnt += e;
        drive(0, 500, 1'b0, c, r, e, b);
    endtask

    initial begin
        int c, r, e, b, bc, cnt;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pix_en", int'(pix_en), 0);
        chk("rst_col", int'(rom_col), 0);
        reset_n = 1'b1;

        // Reset in the middle of a divide
        spr_x = 10'd100; spr_y = 10'd50; spr_size = 10'd64;
        drive(0, 500, 1'b1, c, r, e, b);
        for (int i = 1; i <= 4; i++) drive(i, 500, 1'b0, c, r, e, b);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_en", int'(pix_en), 0);
        drive(5, 500, 1'b0, c, r, e, b);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            drive(i, 500, 1'b0, c, r, e, b);
            cnt += b;
        end
        chk("idle_after_rst", cnt, 0);
        scan_frame(100, 50, 64, 0, cnt);
        chk("idle_frame_px", cnt, 0);

        rom_mode = 0;
        do_load(100, 50, 64, bc);
        chk("busy64", bc, 17);
        scan_frame(100, 50, 64, 1, cnt);
        chk("px64", cnt, 4096);

        do_load(100, 50, 128, bc);
        chk("busy128", bc, 17);
        scan_frame(100, 50, 128, 2, cnt);
        chk("px128", cnt, 16384);

        do_load(100, 50, 0, bc);
        chk("busy0", bc, 0);
        scan_frame(100, 50, 64, 0, cnt);
        chk("px0", cnt, 0);

        do_load(300, 200, 1, bc);
        chk("busy1", bc, 17);
        scan_frame(300, 200, 1, 1, cnt);
        chk("px1", cnt, 1);

        rom_mode = 1;
        do_load(100, 50, 64, bc);
        scan_frame(100, 50, 64, 3, cnt);
        chk("px_key", cnt, 2048);

        rom_mode = 0;
        do_load(600, 50, 64, bc);
        scan_frame(600, 50, 64, 4, cnt);
        chk("px_clip", cnt, 2560);

        // Load coinciding with line end inside the sprite
        for (int vv = 50; vv <= 52; vv++)
            for (int hh = 600; hh < H; hh++) drive(hh, vv, 1'b0, c, r, e, b);
        for (int hh = 600; hh <= 610; hh++) drive(hh, 53, 1'b0, c, r, e, b);
        drive(H - 1, 53, 1'b1, c, r, e, b);
        chk("pre_load_col", c, 11);
        chk("pre_load_row", r, 3);
        drive(0, 500, 1'b0, c, r, e, b);
        chk("load_le_col", c, 0);
        chk("load_le_row", r, 0);
        for (int i = 1; i <= 20; i++) drive(i, 500, 1'b0, c, r, e, b);
        drive(H - 1, V - 1, 1'b0, c, r, e, b);

        for (int n = 0; n < 5; n++) begin
            int x, y, s;
            x = int'($urandom_range(0, 639));
            y = int'($urandom_range(0, 479));
            s = int'($urandom_range(1, 48));
            rom_mode = int'($urandom_range(0, 2));
            do_load(x, y, s, bc);
            chk("busy_rand", bc, 17);
            scan_frame(x, y, s, 0, cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
